oled_text_console: RTL and testbench
====================================

# oled_text_console

Character-stream text console that owns the OLED line buffers. Accepts bytes over a valid/ready handshake, interprets a small set of control codes, and maintains NLINES packed string registers that the OLED driver displays directly. It supersedes hard-coded string assignment in sandbox tops: firmware or other RTL simply streams text into it.

## Interface
- NLINES, 4: text rows; must be at least 2.
- NCHARS, 16: characters per row; must be at least 2.
- FILL, 8'h20: blank character used for reset, clear, scroll-in and backspace.

- GCLK  in  1  system clock, rising edge.
- RST  in  1  reset; asynchronous and active-high.
- CH_DATA  in  8  character or control byte.
- CH_VALID  in  1  CH_DATA valid.
- CH_READY  out  1  console can accept a byte; transfer occurs on a GCLK edge when CH_VALID and CH_READY are both high.
- CLR  in  1  single-cycle clear request.
- OLED_TXT  out  NLINES*NCHARS*8  packed rows. Row 0 occupies the top NCHARS*8 bits. Within a row, column 0 occupies the top byte (string-literal order).
- CUR_LINE  out  $clog2(NLINES)  cursor row.
- CUR_COL  out  $clog2(NCHARS)  cursor column.
- BUSY  out  1  clear or scroll in progress.

## Operation
- States:
  - IDLE: accepts bytes.
  - CLEAR: blanks one row per cycle, rows 0 to NLINES-1.
  - SCROLL: copies row i+1 to row i, one row per cycle for i = 0 to NLINES-2, then blanks row NLINES-1.
- CH_READY = (state == IDLE) && !CLR. It is combinational on CLR. BUSY = (state != IDLE).
- Accepted byte handling, in IDLE:
  - 0x20–0x7E: write the byte at the cursor, then col++. If col was NCHARS-1: col = 0 and advance the line.
  - 0x0A (LF): col = 0, advance the line.
  - 0x0D (CR): col = 0.
  - 0x08 (BS): if col > 0, col-- and write FILL at the new col. At col 0 there is no effect.
  - 0x0C (FF): cursor goes to (0,0) and the console enters CLEAR.
  - Any other byte: consumed, no effect.
- Line advance:
  - If line < NLINES-1: line++.
  - If line == NLINES-1: see Configuration.
- CLR high in any state: cursor goes to (0,0) and the console enters CLEAR with the row counter at 0. An active CLEAR or SCROLL is aborted. A byte presented in the same cycle is not accepted, because CH_READY is low.
- After reset:
  - every OLED_TXT byte = FILL
  - cursor = (0,0)
  - state = IDLE
  - CH_READY = 1
  - BUSY = 0
- RST asserted mid-CLEAR or mid-SCROLL returns the console to exactly the reset state immediately, without waiting for GCLK.

## Timing
- A printable character is visible on OLED_TXT, and the cursor outputs are updated, on the edge that accepts it. Latency is 1 cycle and the console sustains 1 byte per cycle.
- CLEAR lasts exactly NLINES cycles. CH_READY returns high on the cycle after the last row is blanked.
- SCROLL lasts exactly NLINES cycles. Any character that triggered the scroll is written to row NLINES-1 on the accept edge and is moved up by the scroll.
- Rows not being written hold their value. No partial-row glitches: each row changes on at most one edge per operation step.

## Configuration
- OLED_TXT_SCROLL_EN defined: a line advance from row NLINES-1 enters SCROLL. The cursor stays at (NLINES-1, 0).
- OLED_TXT_SCROLL_EN undefined: a line advance from row NLINES-1 wraps the cursor to (0,0). Row 0 is blanked to FILL on the same edge. There is no SCROLL state, and BUSY is only asserted during CLEAR.

## Test plan
- Reset, then stream "SPI interface" (13 bytes, one per cycle): row 0 = "SPI interface" plus 3 FILL, cursor = (0,13), CH_READY never drops.
- Write 16 × 'A' on row 0: row 0 is all 'A' and the cursor is (1,0). Then send 0x08: no change. Then send 'B', 0x08: row 1 col 0 = FILL and the cursor is (1,0).
- With scroll enabled:
  - Fill rows 0–3 with "0", "1", "2", "3" (each followed by LF).
  - Rows become "1", "2", "3", blank.
  - BUSY is high for exactly 4 cycles.
  - The cursor ends at (3,0).
- Same stimulus with scroll disabled: the cursor ends at (0,0), row 0 is blank, and rows 1–3 = "1", "2", "3".
- Send 0x0C while holding CH_VALID with 'X': CH_READY is low for 4 cycles, all rows are FILL, then 'X' lands at (0,0).
- Assert CLR during the second SCROLL cycle: CLEAR restarts at row 0 and completes in 4 cycles. Separately, assert RST mid-CLEAR: outputs return to the reset values asynchronously.

Source files
------------

// File: rtl/oled_text_console_if.sv
// Byte-stream handshake into the OLED text console.
interface oled_text_console_if;
    logic [7:0] CH_DATA;
    logic       CH_VALID;
    logic       CH_READY;

    modport master (output CH_DATA, output CH_VALID, input CH_READY);
    modport slave  (input CH_DATA, input CH_VALID, output CH_READY);
endinterface

// File: rtl/oled_text_console.sv
// Text console owning the OLED row buffers; bytes stream in, rows drive the display directly.
// Build option OLED_TXT_SCROLL_EN: scroll at the bottom row instead of wrapping to row 0.
//
// state     | meaning
// ----------|---------------------------------------------------------
// ST_IDLE   | accepting bytes, interpreting printable and control codes
// ST_CLEAR  | blanking row cnt, rows 0..NLINES-1, one per cycle
// ST_SCROLL | cnt < NLINES-1: row cnt <= row cnt+1; last cycle blanks bottom row
module oled_text_console #(
    parameter int         NLINES = 4,
    parameter int         NCHARS = 16,
    parameter logic [7:0] FILL   = 8'h20
) (
    input  logic                          GCLK,
    input  logic                          RST,
    oled_text_console_if.slave            ch,
    input  logic                          CLR,
    output logic [NLINES*NCHARS*8-1:0]    OLED_TXT,
    output logic [$clog2(NLINES)-1:0]     CUR_LINE,
    output logic [$clog2(NCHARS)-1:0]     CUR_COL,
    output logic                          BUSY
);
    localparam int LW = $clog2(NLINES);
    localparam int CW = $clog2(NCHARS);
    localparam int RW = NCHARS * 8;
    localparam logic [LW-1:0] LAST_LINE = LW'(NLINES - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(NCHARS - 1);
    localparam logic [RW-1:0] BLANK     = {NCHARS{FILL}};

`ifdef OLED_TXT_SCROLL_EN
    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_SCROLL} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR} state_t;
`endif

    state_t          state, state_nxt;
    logic [LW-1:0]   cnt, cnt_nxt;
    logic [LW-1:0]   cur_line, line_nxt;
    logic [CW-1:0]   cur_col, col_nxt;
    logic [RW-1:0]   rows     [NLINES];
    logic [RW-1:0]   rows_nxt [NLINES];
    logic            adv;
    logic            wr_en;
    logic [CW-1:0]   wr_col;
    logic [7:0]      wr_byte;

    // Column 0 sits in the top byte of a row, matching string-literal order.
    function automatic logic [RW-1:0] put_char(input logic [RW-1:0] r,
                                               input logic [CW-1:0] c,
                                               input logic [7:0]    b);
        logic [RW-1:0] o;
        o = r;
        o[(NCHARS - 1 - int'(c)) * 8 +: 8] = b;
        return o;
    endfunction

    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cur_line <= '0;
            cur_col  <= '0;
            for (int i = 0; i < NLINES; i++) rows[i] <= BLANK;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cur_line <= line_nxt;
            cur_col  <= col_nxt;
            for (int i = 0; i < NLINES; i++) rows[i] <= rows_nxt[i];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        line_nxt  = cur_line;
        col_nxt   = cur_col;
        rows_nxt  = rows;
        adv       = 1'b0;
        wr_en     = 1'b0;
        wr_col    = cur_col;
        wr_byte   = ch.CH_DATA;

        if (CLR) begin
            state_nxt = ST_CLEAR;
            cnt_nxt   = '0;
            line_nxt  = '0;
            col_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ch.CH_VALID) begin
                        if (ch.CH_DATA >= 8'h20 && ch.CH_DATA <= 8'h7E) begin
                            wr_en = 1'b1;
                            if (cur_col == LAST_COL) begin
                                col_nxt = '0;
                                adv     = 1'b1;
                            end else begin
                                col_nxt = cur_col + 1'b1;
                            end
                        end else begin
                            case (ch.CH_DATA)
                                8'h0A: begin
                                    col_nxt = '0;
                                    adv     = 1'b1;
                                end
                                8'h0D: col_nxt = '0;
                                8'h08: begin
                                    if (cur_col != '0) begin
                                        col_nxt = cur_col - 1'b1;
                                        wr_en   = 1'b1;
                                        wr_col  = cur_col - 1'b1;
                                        wr_byte = FILL;
                                    end
                                end
                                8'h0C: begin
                                    line_nxt  = '0;
                                    col_nxt   = '0;
                                    cnt_nxt   = '0;
                                    state_nxt = ST_CLEAR;
                                end
                                default: ;
                            endcase
                        end

                        if (adv) begin
                            if (cur_line != LAST_LINE) begin
                                line_nxt = cur_line + 1'b1;
                            end else begin
`ifdef OLED_TXT_SCROLL_EN
                                state_nxt = ST_SCROLL;
                                cnt_nxt   = '0;
`else
                                line_nxt    = '0;
                                rows_nxt[0] = BLANK;
`endif
                            end
                        end
                    end
                end

                ST_CLEAR: begin
                    for (int i = 0; i < NLINES; i++)
                        if (cnt == LW'(i)) rows_nxt[i] = BLANK;
                    if (cnt == LAST_LINE) state_nxt = ST_IDLE;
                    else                  cnt_nxt   = cnt + 1'b1;
                end

`ifdef OLED_TXT_SCROLL_EN
                ST_SCROLL: begin
                    for (int i = 0; i < NLINES - 1; i++)
                        if (cnt == LW'(i)) rows_nxt[i] = rows[i+1];
                    if (cnt == LAST_LINE) begin
                        rows_nxt[NLINES-1] = BLANK;
                        state_nxt          = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
`endif

                default: state_nxt = ST_IDLE;
            endcase
        end

        // The written cell is always on the cursor row, never the row blanked on a wrap.
        if (wr_en) begin
            for (int i = 0; i < NLINES; i++)
                if (cur_line == LW'(i)) rows_nxt[i] = put_char(rows[i], wr_col, wr_byte);
        end
    end

    for (genvar g = 0; g < NLINES; g++) begin : g_pack
        assign OLED_TXT[(NLINES - 1 - g) * RW +: RW] = rows[g];
    end

    assign ch.CH_READY = (state == ST_IDLE) && !CLR;
    assign BUSY        = (state != ST_IDLE);
    assign CUR_LINE    = cur_line;
    assign CUR_COL     = cur_col;
endmodule

// File: tb/tb_oled_text_console.sv
// Directed self-checking bench for oled_text_console (4 rows x 16 chars, FILL = space).
module tb_oled_text_console;
    logic         GCLK;
    logic         RST;
    logic         CLR;
    logic [511:0] OLED_TXT;
    logic [1:0]   CUR_LINE;
    logic [3:0]   CUR_COL;
    logic         BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    oled_text_console_if ifc ();

    oled_text_console #(.NLINES(4), .NCHARS(16), .FILL(8'h20)) dut (
        .GCLK     (GCLK),
        .RST      (RST),
        .ch       (ifc),
        .CLR      (CLR),
        .OLED_TXT (OLED_TXT),
        .CUR_LINE (CUR_LINE),
        .CUR_COL  (CUR_COL),
        .BUSY     (BUSY)
    );

    initial GCLK = 1'b0;
    always #5 GCLK = ~GCLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] row(input int i);
        return OLED_TXT[(3 - i) * 128 +: 128];
    endfunction

    // Expected row: text left-justified, remainder spaces.
    function automatic logic [127:0] pad(input string s);
        logic [127:0] r;
        r = {16{8'h20}};
        for (int i = 0; i < s.len() && i < 16; i++) r[(15 - i) * 8 +: 8] = s[i];
        return r;
    endfunction

    task automatic send(input logic [7:0] b, output int stalls);
        stalls = 0;
        ifc.CH_DATA  = b;
        ifc.CH_VALID = 1'b1;
        while (!ifc.CH_READY && stalls < 50) begin
            @(posedge GCLK); #1;
            stalls++;
        end
        if (stalls >= 50) check("ready_timeout", 0, 1);
        @(posedge GCLK); #1;
        ifc.CH_VALID = 1'b0;
    endtask

    task automatic send_str(input string s, output int stalls);
        int st;
        stalls = 0;
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], st);
            stalls += st;
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (BUSY && n < 50) begin
            @(posedge GCLK); #1;
            n++;
        end
    endtask

    task automatic pulse_clr(output int n);
        CLR = 1'b1;
        @(posedge GCLK); #1;
        CLR = 1'b0;
        count_busy(n);
    endtask

    task automatic check_all_blank(input string tag);
        for (int i = 0; i < 4; i++) check(tag, row(i), pad(""));
    endtask

    initial begin
        int st;
        int n;
        RST          = 1'b1;
        CLR          = 1'b0;
        ifc.CH_DATA  = 8'h00;
        ifc.CH_VALID = 1'b0;
        repeat (2) @(posedge GCLK);
        #1 RST = 1'b0;

        check_all_blank("reset_rows");
        check("reset_line", CUR_LINE, 0);
        check("reset_col", CUR_COL, 0);
        check("reset_ready", ifc.CH_READY, 1);
        check("reset_busy", BUSY, 0);

        send_str("SPI interface", st);
        check("spi_row0", row(0), pad("SPI interface"));
        check("spi_line", CUR_LINE, 0);
        check("spi_col", CUR_COL, 13);
        check("spi_stalls", st, 0);

        // Form feed with 'X' held on the bus behind it.
        send(8'h0C, st);
        ifc.CH_DATA  = "X";
        ifc.CH_VALID = 1'b1;
        n = 0;
        while (!ifc.CH_READY && n < 50) begin
            @(posedge GCLK); #1;
            n++;
        end
        check("ff_ready_low", n, 4);
        check_all_blank("ff_blank");
        @(posedge GCLK); #1;
        ifc.CH_VALID = 1'b0;
        check("ff_x_row0", row(0), pad("X"));
        check("ff_x_col", CUR_COL, 1);
        check("ff_x_line", CUR_LINE, 0);

        CLR = 1'b1;
        #1 check("clr_ready_comb", ifc.CH_READY, 0);
        @(posedge GCLK); #1;
        CLR = 1'b0;
        count_busy(n);
        check("clr_cycles", n, 4);
        check_all_blank("clr_blank");

        send_str("AAAAAAAAAAAAAAAA", st);
        check("wrap_row0", row(0), {16{8'h41}});
        check("wrap_line", CUR_LINE, 1);
        check("wrap_col", CUR_COL, 0);
        send(8'h08, st);
        check("bs0_line", CUR_LINE, 1);
        check("bs0_col", CUR_COL, 0);
        check("bs0_row1", row(1), pad(""));
        send("B", st);
        check("b_row1", row(1), pad("B"));
        send(8'h08, st);
        check("bs_row1", row(1), pad(""));
        check("bs_col", CUR_COL, 0);
        check("bs_line", CUR_LINE, 1);
        send_str("ab", st);
        send(8'h0D, st);
        send("c", st);
        send(8'h01, st);
        check("cr_row1", row(1), pad("cb"));
        check("cr_col", CUR_COL, 1);

        pulse_clr(n);
        send_str("0\n1\n2\n3\n", st);
        count_busy(n);
`ifdef OLED_TXT_SCROLL_EN
        check("scroll_busy", n, 4);
        check("scroll_row0", row(0), pad("1"));
        check("scroll_row1", row(1), pad("2"));
        check("scroll_row2", row(2), pad("3"));
        check("scroll_row3", row(3), pad(""));
        check("scroll_line", CUR_LINE, 3);
        check("scroll_col", CUR_COL, 0);
        // Start another scroll and abort it in its second cycle.
        send(8'h0A, st);
        @(posedge GCLK); #1;
        check("abort_row0", row(0), pad("2"));
`else
        check("noscroll_busy", n, 0);
        check("noscroll_row0", row(0), pad(""));
        check("noscroll_row1", row(1), pad("1"));
        check("noscroll_row2", row(2), pad("2"));
        check("noscroll_row3", row(3), pad("3"));
        check("noscroll_line", CUR_LINE, 0);
        check("noscroll_col", CUR_COL, 0);
        // Start a clear and abort it in its second cycle.
        send(8'h0C, st);
        @(posedge GCLK); #1;
        check("abort_row1", row(1), pad("1"));
`endif
        CLR = 1'b1;
        @(posedge GCLK); #1;
        CLR = 1'b0;
        count_busy(n);
        check("abort_cycles", n, 4);
        check_all_blank("abort_blank");
        check("abort_line", CUR_LINE, 0);

        // Asynchronous reset in the middle of a clear.
        send_str("\n\nQQ\nRR", st);
        CLR = 1'b1;
        @(posedge GCLK); #1;
        CLR = 1'b0;
        @(posedge GCLK); #1;
        check("mid_row2", row(2), pad("QQ"));
        check("mid_busy", BUSY, 1);
        #2 RST = 1'b1;
        #1;
        check_all_blank("rst_async_rows");
        check("rst_async_busy", BUSY, 0);
        check("rst_async_ready", ifc.CH_READY, 1);
        check("rst_async_line", CUR_LINE, 0);
        check("rst_async_col", CUR_COL, 0);
        @(posedge GCLK); #1;
        RST = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
